// File: rtl/serial_subtractor16.sv
// -----------------------------------------------------------------------------
// serial_subtractor16
//
// Bit-serial two's-complement subtractor that computes A - B. It uses one
// full-subtractor cell per clock, a shift register for the result, and a
// borrow flip-flop that carries between cycles.
//
// Operator model:
//   - A follows the switches while idle.
//   - B is loaded from the switches on a LoadB press.
//   - A Run press (1->0 edge) starts one WIDTH-cycle subtraction.
//
// Optional feature (macro SERSUB_OVF_EN):
//   - Adds output V, the signed overflow flag of the last completed result.
//
// Ports:
//   Clk    in   system clock
//   Reset  in   asynchronous active-low reset, clears all state
//   LoadB  in   active-low button, loads SW into B while idle
//   Run    in   active-low button, a 1->0 edge starts one subtraction
//   SW     in   [WIDTH] switches, operand source
//   Diff   out  [WIDTH] registered A - B (mod 2^WIDTH)
//   BO     out  registered borrow-out, 1 iff A < B unsigned
//   Busy   out  high while bits are being processed
//   Done   out  high from completion until Run is released
//   V      out  signed overflow (only with SERSUB_OVF_EN)
// -----------------------------------------------------------------------------
module serial_subtractor16 #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] Diff,
  output logic             BO,
  output logic             Busy,
  output logic             Done
`ifdef SERSUB_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, s_q;
  logic               borrow_q;
  logic [CNT_W-1:0]   count_q;
  logic               run_q;

  logic               start;
  logic               last;
  logic               d_bit;
  logic               borrow_nxt;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   b_rot;

  // Full-subtractor cell on the LSBs of S and B. The new difference bit
  // enters the result at the top while S shifts right.
  assign d_bit      = s_q[0] ^ b_q[0] ^ borrow_q;
  assign borrow_nxt = (~s_q[0] & b_q[0]) | (~(s_q[0] ^ b_q[0]) & borrow_q);
  assign result     = {d_bit, s_q[WIDTH-1:1]};

  // B rotates instead of shifting, so after WIDTH cycles it holds its
  // original value again. No reload is needed for the next operation.
  assign b_rot      = {b_q[0], b_q[WIDTH-1:1]};

  // State register.
  // NOTE: all clocked state uses non-blocking (<=) assignments, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and status outputs.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    Busy    = 1'b0;
    Done    = 1'b0;
    start   = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A LoadB press has priority and swallows a coincident Run edge.
        start = run_q & ~Run & LoadB;
        if (start) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        Busy = 1'b1;
        last = (count_q == CNT_W'(WIDTH - 1));
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        Done = 1'b1;
        // Holding Run low keeps the block here, so one press gives exactly
        // one operation.
        if (Run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand, shift and result registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      run_q    <= 1'b1;
      Diff     <= '0;
      BO       <= 1'b0;
`ifdef SERSUB_OVF_EN
      V        <= 1'b0;
`endif
    end else begin
      run_q <= Run;
      unique case (state_q)
        S_IDLE: begin
          if (!LoadB) b_q <= SW;
          else        a_q <= SW;
          // S takes the pre-edge A, which is the value the switches held
          // on the cycle before the press was seen.
          if (start) begin
            s_q      <= a_q;
            borrow_q <= 1'b0;
            count_q  <= '0;
          end
        end
        S_SHIFT: begin
          s_q      <= result;
          borrow_q <= borrow_nxt;
          b_q      <= b_rot;
          count_q  <= count_q + CNT_W'(1);
          if (last) begin
            Diff <= result;
            BO   <= borrow_nxt;
`ifdef SERSUB_OVF_EN
            // Signs of the operands differ, and the sign of the result
            // differs from the sign of A.
            V    <= (a_q[WIDTH-1] ^ b_rot[WIDTH-1]) &
                    (a_q[WIDTH-1] ^ result[WIDTH-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor16.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor16
//
// Self-checking bench for serial_subtractor16.
//
// Expected results come from plain arithmetic on the operands:
//   - Diff = a - b (mod 2^16)
//   - BO   = a < b
//   - V    = signed overflow
//
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_subtractor16;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        LoadB = 1'b1;
  logic        Run = 1'b1;
  logic [15:0] SW = '0;
  logic [15:0] Diff;
  logic        BO;
  logic        Busy;
  logic        Done;
`ifdef SERSUB_OVF_EN
  logic        V;
  logic        exp_v = 1'b0;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_diff = '0;
  logic        exp_bo = 1'b0;

  serial_subtractor16 dut (
    .Clk   (Clk),
    .Reset (Reset),
    .LoadB (LoadB),
    .Run   (Run),
    .SW    (SW),
    .Diff  (Diff),
    .BO    (BO),
    .Busy  (Busy),
    .Done  (Done)
`ifdef SERSUB_OVF_EN
    ,
    .V     (V)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_diff"}, Diff, exp_diff);
    check({tag, "_bo"},   BO,   exp_bo);
`ifdef SERSUB_OVF_EN
    check({tag, "_v"},    V,    exp_v);
`endif
  endtask

  // Behavioural reference: plain two's-complement arithmetic.
  task automatic model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] d;
    d        = a - b;
    exp_diff = d;
    exp_bo   = (a < b);
`ifdef SERSUB_OVF_EN
    exp_v    = (a[15] != b[15]) && (d[15] != a[15]);
`endif
  endtask

  // One full operation:
  //   - optionally load B, then present A;
  //   - press Run and count the Busy cycles;
  //   - check the result, optionally holding Run low for `hold` cycles;
  //   - release Run and check that Done drops.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input bit do_load, input bit scramble, input int hold);
    int busy_n;
    int bad;
    bit seen_done;
    if (do_load) begin
      @(negedge Clk); LoadB = 1'b0; SW = b; Run = 1'b1;
    end
    @(negedge Clk); LoadB = 1'b1; SW = a; Run = 1'b1;
    @(negedge Clk); Run = 1'b0;
    busy_n    = 0;
    seen_done = 0;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      @(negedge Clk);
      if (Done) begin
        seen_done = 1;
      end else begin
        if (Busy) busy_n++;
        // Results from the previous operation must hold during SHIFT.
        check("hold_diff", Diff, exp_diff);
        if (scramble) SW = 16'($urandom);
      end
    end
    check("done_seen", 32'(seen_done), 1);
    check("busy_cycles", busy_n, 16);
    model(a, b);
    check_outputs("result");
    check("busy_after", Busy, 0);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      if (!Done || Busy) bad++;
    end
    if (hold > 0) check("held_run_single_op", bad, 0);
    @(negedge Clk); Run = 1'b1; SW = a;
    @(negedge Clk);
    check("done_released", Done, 0);
    check("idle_not_busy", Busy, 0);
  endtask

  initial begin
    logic [15:0] ra, rb;

    // Reset state.
    #12;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check_outputs("rst");
    @(negedge Clk); Reset = 1'b1;

    // Directed cases.
    run_op(16'h0005, 16'h0003, 1, 0, 0);
    run_op(16'h0003, 16'h0005, 1, 0, 0);
    run_op(16'hFFFF, 16'hFFFF, 1, 0, 0);
    run_op(16'h8000, 16'h0001, 1, 0, 0);
    run_op(16'h0001, 16'h0001, 1, 0, 0);
    run_op(16'h7FFF, 16'hFFFF, 1, 0, 0);

    // Run held low for 100 cycles; SW toggles during SHIFT.
    run_op(16'h1234, 16'h0FED, 1, 1, 100);

    // Reset during the 8th SHIFT cycle.
    @(negedge Clk); LoadB = 1'b0; SW = 16'h0F0F;
    @(negedge Clk); LoadB = 1'b1; SW = 16'hA5A5;
    @(negedge Clk); Run = 1'b0;
    repeat (8) @(negedge Clk);
    check("mid_busy", Busy, 1);
    Reset = 1'b0;
    #1;
    exp_diff = '0;
    exp_bo   = 1'b0;
`ifdef SERSUB_OVF_EN
    exp_v    = 1'b0;
`endif
    check_outputs("abort");
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    @(negedge Clk);
    check("abort_idle", Busy, 0);
    Run = 1'b1;
    @(negedge Clk); Reset = 1'b1;
    run_op(16'h4321, 16'h1111, 1, 0, 0);

    // LoadB and the Run edge on the same cycle: B loads, nothing starts.
    @(negedge Clk); LoadB = 1'b0; SW = 16'h0100; Run = 1'b0;
    @(negedge Clk);
    check("collide_busy0", Busy, 0);
    @(negedge Clk);
    check("collide_busy1", Busy, 0);
    check("collide_done", Done, 0);
    LoadB = 1'b1; Run = 1'b1;
    run_op(16'h0050, 16'h0100, 0, 0, 0);

    // Random operands.
    for (int k = 0; k < 20; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, 1, k[0], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got no end, expected end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor16.md
# serial_subtractor16

Bit-serial two's-complement subtractor for the Lab 4 board top level. It computes A − B one bit per clock through a single full-subtractor cell and a shift register, with a borrow flip-flop between cycles. It uses the same push-button and switch operator model as the adder demos: A follows the switches, B is loaded on a button press, and Run starts an operation. It sits in place of an adder instance and drives the red LEDs (Diff) and the green LED (BO).

## Interface
- WIDTH, 16, operand/result width in bits (≥2); bit counter is $clog2(WIDTH) bits
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  asynchronous, active-low; clears all state
- LoadB  in  1  active-low push-button; loads SW into B while idle
- Run  in  1  active-low push-button; a press (sampled 1→0) starts one subtraction
- SW  in  WIDTH  slider switches, operand source
- Diff  out  WIDTH  registered result A − B (mod 2^WIDTH)
- BO  out  1  registered borrow-out; 1 iff A < B unsigned
- Busy  out  1  high while bits are being processed
- Done  out  1  high from completion until Run is released
- V  out  1  signed overflow flag (present only with SERSUB_OVF_EN)

## Operation
- Reset values: Diff=0, BO=0, Busy=0, Done=0, V=0, A=0, B=0, S=0, borrow=0, count=0, Run_q=1, state=IDLE.
- **IDLE**
  - If LoadB=0: B <= SW. LoadB has priority, so any Run edge on the same cycle is discarded.
  - Else: A <= SW every cycle.
  - If Run_q=1, Run=0 and LoadB=1: S <= A (the pre-edge value), borrow <= 0, count <= 0, go to SHIFT.
- **SHIFT** (Busy=1)
  - Each cycle: d = S[0]^B[0]^borrow; borrow <= (~S[0]&B[0]) | (~(S[0]^B[0])&borrow).
  - S <= {d, S[WIDTH-1:1]}; B rotates right by one, so B is restored after WIDTH cycles; count++.
  - LoadB and SW are ignored; A is frozen.
  - On count==WIDTH-1: Diff <= {d, S[WIDTH-1:1]}, BO <= final borrow, go to DONE.
- **DONE** (Done=1, Busy=0)
  - A and B are frozen.
  - When Run is sampled 1, go to IDLE.
  - One press produces exactly one operation, no matter how long Run is held.
- Run_q is the Run input registered every cycle, used for edge detection.
- Diff and BO hold their values until the next completion or reset.
- Reset asserted mid-operation aborts it immediately; the partial result is never written to Diff.

## Timing
- Run edge detected at clock edge t0 → state SHIFT after t0.
- Bit i is processed at edge t0+1+i.
- At edge t0+WIDTH: Diff and BO valid, Done=1, Busy=0.
- Latency is WIDTH clocks from the press-detect edge (16 for the default).
- Busy is high for exactly WIDTH cycles.
- The earliest next start is one cycle after Run is seen released, followed by a new 1→0 edge.
- Diff and BO change only on the completion edge.

## Configuration
- SERSUB_OVF_EN defined:
  - Adds output V, reset 0.
  - On the completion edge, V <= (A[WIDTH-1]^B[WIDTH-1]) & (A[WIDTH-1]^result[WIDTH-1]), using the frozen A and the restored B.
  - V holds until the next completion.
- SERSUB_OVF_EN undefined:
  - Port V does not exist and no overflow logic is generated.
  - All other behaviour is identical.

## Test plan
- A=0x0005, B=0x0003, press Run → after 16 clocks Diff=0x0002, BO=0, Busy high for exactly 16 cycles, Done=1.
- A=0x0003, B=0x0005 → Diff=0xFFFE, BO=1; A=B=0xFFFF → Diff=0x0000, BO=0.
- A=0x8000, B=0x0001 → Diff=0x7FFF, BO=0, V=1 (with macro); A=0x0001, B=0x0001 → V=0.
- Assert Reset at the 8th SHIFT cycle → all outputs 0, state IDLE on the next edge; a later press computes correctly from fresh operands.
- Hold Run low for 100 cycles → one operation only, Done stays 1 until release; changing SW during SHIFT has no effect on Diff.
- LoadB=0 and Run falling on the same cycle → B=SW, no operation (Busy stays 0); a second press then subtracts the new B.
